// File: rtl/mips_alu_pkg.sv
// Purpose : shared encodings for the MIPS ALU/control slice (opcodes, funct, regimm, selects).
// Latency : n/a (declarations only).
// Backpr. : n/a.
package mips_alu_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LWL     = 6'h22;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_LWR     = 6'h26;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   // SPECIAL funct codes (instr[5:0])
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   // REGIMM rt codes (instr[20:16])
   localparam logic [4:0] RI_BLTZ   = 5'h00;
   localparam logic [4:0] RI_BGEZ   = 5'h01;
   localparam logic [4:0] RI_BLTZAL = 5'h10;
   localparam logic [4:0] RI_BGEZAL = 5'h11;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_t;

   typedef enum logic [2:0] {
      MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
   } md_op_t;

   localparam logic [1:0] PC_PLUS4    = 2'd0;
   localparam logic [1:0] PC_BRANCH   = 2'd1;
   localparam logic [1:0] PC_JUMP_IMM = 2'd2;
   localparam logic [1:0] PC_JUMP_REG = 2'd3;

   localparam logic [1:0] REG_ADDR_RT  = 2'd0;
   localparam logic [1:0] REG_ADDR_RD  = 2'd1;
   localparam logic [1:0] REG_ADDR_R31 = 2'd2;

   localparam logic [1:0] REG_DATA_ALU     = 2'd0;
   localparam logic [1:0] REG_DATA_MEM_RAW = 2'd1;
   localparam logic [1:0] REG_DATA_MEM_EXT = 2'd2;
   localparam logic [1:0] REG_DATA_LINK    = 2'd3;

endpackage

// File: rtl/mips_alu_core.sv
// Purpose : combinational MIPS integer ALU (add/sub, logic, compares, shifts, LUI).
// Latency : 0 cycles, purely combinational.
// Backpr. : none.
// Ports   : op (alu_op_t), a/b operands, shamt shift amount applied to b, result.
module mips_alu_core
   import mips_alu_pkg::*;
(
   input  alu_op_t     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   output logic [31:0] result
);

   always_comb begin
      result = 32'h0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {31'h0, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {31'h0, (a < b)};
         ALU_SLL:  result = b << shamt;
         ALU_SRL:  result = b >> shamt;
         ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
         // b carries the extended immediate; the upper half shifts out
         ALU_LUI:  result = b << 16;
         default:  result = 32'h0;
      endcase
   end

endmodule

// File: rtl/mips_alu_control_unit.sv
// Purpose : MIPS instruction decode, branch resolution, store lane generation and HI/LO registers.
// Latency : all outputs except hi/lo combinational; hi/lo update at the next clk edge with active & clk_enable.
// Backpr. : none; active/clk_enable suppress write/memory strobes and freeze HI/LO.
// Ports   : clk, reset (sync, high), clk_enable, active, instr, reg_a, reg_b in;
//           alu_result, byte_offset, branch/pc/regfile/memory controls, hi, lo out.
// Config  : MIPS_MULDIV_EN enables MULT/MULTU/DIV/DIVU/MTHI/MTLO; otherwise HI/LO stay 0.
module mips_alu_control_unit
   import mips_alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        active,
   input  logic [31:0] instr,
   input  logic [31:0] reg_a,
   input  logic [31:0] reg_b,
   output logic [31:0] alu_result,
   output logic [1:0]  byte_offset,
   output logic        branch_taken,
   output logic        is_branch,
   output logic [1:0]  pc_sel,
   output logic        reg_write_enable,
   output logic [1:0]  reg_addr_sel,
   output logic [1:0]  reg_data_sel,
   output logic        signextend_sel,
   output logic [1:0]  lwlr_sel,
   output logic        data_read,
   output logic        data_write,
   output logic [3:0]  byte_enable,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   logic [5:0]  opcode, funct;
   logic [4:0]  rt;
   logic [15:0] imm;
   logic        en, a_eq_b, a_neg, a_zero;
   alu_op_t     alu_op;
   logic        b_imm, imm_zext, var_shift, sel_hi, sel_lo;
   logic        wr, rd_mem, wr_mem, be_full, st_byte, st_half, taken;
   logic [31:0] alu_b, core_res;
   logic [4:0]  shamt;
   logic        unused_rs_bits;
`ifdef MIPS_MULDIV_EN
   md_op_t      md_op;
`endif

   assign opcode = instr[31:26];
   assign rt     = instr[20:16];
   assign imm    = instr[15:0];
   assign funct  = instr[5:0];
   // rs selects reg_a upstream; this block only sees its contents
   assign unused_rs_bits = ^instr[25:21];

   assign en     = active & clk_enable;
   assign a_eq_b = (reg_a == reg_b);
   assign a_neg  = reg_a[31];
   assign a_zero = (reg_a == 32'h0);

   always_comb begin
      alu_op = ALU_ADD;   b_imm = 1'b0;   imm_zext = 1'b0;  var_shift = 1'b0;
      sel_hi = 1'b0;      sel_lo = 1'b0;  wr = 1'b0;        rd_mem = 1'b0;
      wr_mem = 1'b0;      be_full = 1'b0; st_byte = 1'b0;   st_half = 1'b0;
      taken = 1'b0;       is_branch = 1'b0;                 pc_sel = PC_PLUS4;
      reg_addr_sel = REG_ADDR_RT;  reg_data_sel = REG_DATA_ALU;
      signextend_sel = 1'b0;       lwlr_sel = 2'b00;
`ifdef MIPS_MULDIV_EN
      md_op = MD_NONE;
`endif
      case (opcode)
         OP_SPECIAL: begin
            reg_addr_sel = REG_ADDR_RD;
            case (funct)
               FN_ADDU: begin alu_op = ALU_ADD;  wr = 1'b1; end
               FN_SUBU: begin alu_op = ALU_SUB;  wr = 1'b1; end
               FN_AND:  begin alu_op = ALU_AND;  wr = 1'b1; end
               FN_OR:   begin alu_op = ALU_OR;   wr = 1'b1; end
               FN_XOR:  begin alu_op = ALU_XOR;  wr = 1'b1; end
               FN_NOR:  begin alu_op = ALU_NOR;  wr = 1'b1; end
               FN_SLT:  begin alu_op = ALU_SLT;  wr = 1'b1; end
               FN_SLTU: begin alu_op = ALU_SLTU; wr = 1'b1; end
               FN_SLL:  begin alu_op = ALU_SLL;  wr = 1'b1; end
               FN_SRL:  begin alu_op = ALU_SRL;  wr = 1'b1; end
               FN_SRA:  begin alu_op = ALU_SRA;  wr = 1'b1; end
               FN_SLLV: begin alu_op = ALU_SLL;  wr = 1'b1; var_shift = 1'b1; end
               FN_SRLV: begin alu_op = ALU_SRL;  wr = 1'b1; var_shift = 1'b1; end
               FN_SRAV: begin alu_op = ALU_SRA;  wr = 1'b1; var_shift = 1'b1; end
               FN_JR:   begin is_branch = 1'b1; pc_sel = PC_JUMP_REG; end
               FN_JALR: begin
                  is_branch = 1'b1; pc_sel = PC_JUMP_REG;
                  wr = 1'b1; reg_data_sel = REG_DATA_LINK;
               end
               FN_MFHI: begin sel_hi = 1'b1; wr = 1'b1; end
               FN_MFLO: begin sel_lo = 1'b1; wr = 1'b1; end
`ifdef MIPS_MULDIV_EN
               FN_MULT:  md_op = MD_MULT;
               FN_MULTU: md_op = MD_MULTU;
               FN_DIV:   md_op = MD_DIV;
               FN_DIVU:  md_op = MD_DIVU;
               FN_MTHI:  md_op = MD_MTHI;
               FN_MTLO:  md_op = MD_MTLO;
`endif
               default: ;
            endcase
         end
         OP_REGIMM: begin
            case (rt)
               RI_BLTZ:   begin is_branch = 1'b1; taken = a_neg;  end
               RI_BGEZ:   begin is_branch = 1'b1; taken = !a_neg; end
               RI_BLTZAL, RI_BGEZAL: begin
                  // link register is written whether or not the branch is taken
                  is_branch = 1'b1;
                  taken = (rt == RI_BLTZAL) ? a_neg : !a_neg;
                  wr = 1'b1; reg_addr_sel = REG_ADDR_R31; reg_data_sel = REG_DATA_LINK;
               end
               default: ;
            endcase
         end
         OP_J:    begin is_branch = 1'b1; pc_sel = PC_JUMP_IMM; end
         OP_JAL:  begin
            is_branch = 1'b1; pc_sel = PC_JUMP_IMM;
            wr = 1'b1; reg_addr_sel = REG_ADDR_R31; reg_data_sel = REG_DATA_LINK;
         end
         OP_BEQ:  begin is_branch = 1'b1; taken = a_eq_b;            end
         OP_BNE:  begin is_branch = 1'b1; taken = !a_eq_b;           end
         OP_BLEZ: begin is_branch = 1'b1; taken = a_neg | a_zero;    end
         OP_BGTZ: begin is_branch = 1'b1; taken = !a_neg & !a_zero;  end
         OP_ADDIU: begin b_imm = 1'b1; wr = 1'b1; end
         OP_SLTI:  begin b_imm = 1'b1; wr = 1'b1; alu_op = ALU_SLT;  end
         OP_SLTIU: begin b_imm = 1'b1; wr = 1'b1; alu_op = ALU_SLTU; end
         OP_ANDI:  begin b_imm = 1'b1; wr = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND; end
         OP_ORI:   begin b_imm = 1'b1; wr = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR;  end
         OP_XORI:  begin b_imm = 1'b1; wr = 1'b1; imm_zext = 1'b1; alu_op = ALU_XOR; end
         OP_LUI:   begin b_imm = 1'b1; wr = 1'b1; alu_op = ALU_LUI; end
         OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR: begin
            b_imm = 1'b1; wr = 1'b1; rd_mem = 1'b1; be_full = 1'b1;
            case (opcode)
               OP_LW:  reg_data_sel = REG_DATA_MEM_RAW;
               OP_LWL: begin reg_data_sel = REG_DATA_MEM_RAW; lwlr_sel = 2'b11; end
               OP_LWR: begin reg_data_sel = REG_DATA_MEM_RAW; lwlr_sel = 2'b10; end
               default: begin
                  reg_data_sel   = REG_DATA_MEM_EXT;
                  signextend_sel = (opcode == OP_LB) || (opcode == OP_LH);
               end
            endcase
         end
         OP_SB: begin b_imm = 1'b1; wr_mem = 1'b1; st_byte = 1'b1; end
         OP_SH: begin b_imm = 1'b1; wr_mem = 1'b1; st_half = 1'b1; end
         OP_SW: begin b_imm = 1'b1; wr_mem = 1'b1; be_full = 1'b1; end
         default: ;
      endcase
      if (taken)
         pc_sel = PC_BRANCH;
   end

   assign alu_b = !b_imm   ? reg_b :
                  imm_zext ? {16'h0, imm} : {{16{imm[15]}}, imm};
   assign shamt = var_shift ? reg_a[4:0] : instr[10:6];

   mips_alu_core u_core (
      .op     (alu_op),
      .a      (reg_a),
      .b      (alu_b),
      .shamt  (shamt),
      .result (core_res)
   );

   assign alu_result   = sel_hi ? hi : (sel_lo ? lo : core_res);
   assign byte_offset  = alu_result[1:0];
   assign branch_taken = taken;

   assign reg_write_enable = wr & en;
   assign data_read        = rd_mem & en;
   assign data_write       = wr_mem & en;

   always_comb begin
      byte_enable = 4'b0000;
      if (en) begin
         if (be_full)      byte_enable = 4'b1111;
         else if (st_byte) byte_enable = 4'b0001 << core_res[1:0];
         else if (st_half) byte_enable = core_res[1] ? 4'b1100 : 4'b0011;
      end
   end

`ifdef MIPS_MULDIV_EN
   logic [63:0] prod_s, prod_u;
   logic [31:0] quot_s, rem_s, quot_u, rem_u;

   assign prod_s = {{32{reg_a[31]}}, reg_a} * {{32{reg_b[31]}}, reg_b};
   assign prod_u = {32'h0, reg_a} * {32'h0, reg_b};
   // SV signed division truncates toward zero, matching MIPS DIV
   assign quot_s = $unsigned($signed(reg_a) / $signed(reg_b));
   assign rem_s  = $unsigned($signed(reg_a) % $signed(reg_b));
   assign quot_u = reg_a / reg_b;
   assign rem_u  = reg_a % reg_b;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= 32'h0;
         lo <= 32'h0;
      end
`ifdef MIPS_MULDIV_EN
      else if (en) begin
         case (md_op)
            MD_MULT:  {hi, lo} <= prod_s;
            MD_MULTU: {hi, lo} <= prod_u;
            MD_DIV:   if (reg_b != 32'h0) begin lo <= quot_s; hi <= rem_s; end
            MD_DIVU:  if (reg_b != 32'h0) begin lo <= quot_u; hi <= rem_u; end
            MD_MTHI:  hi <= reg_a;
            MD_MTLO:  lo <= reg_a;
            default: ;
         endcase
      end
`endif
   end

endmodule

// File: tb/tb_mips_alu_control_unit.sv
// Purpose : directed self-checking bench for mips_alu_control_unit.
// Latency : combinational outputs checked 1ns after inputs change; HI/LO 1ns after the edge.
// Backpr. : n/a.
module tb_mips_alu_control_unit;

`ifdef MIPS_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, clk_enable, active;
   logic [31:0] instr, reg_a, reg_b;
   logic [31:0] alu_result, hi, lo;
   logic [1:0]  byte_offset, pc_sel, reg_addr_sel, reg_data_sel, lwlr_sel;
   logic        branch_taken, is_branch, reg_write_enable, signextend_sel;
   logic        data_read, data_write;
   logic [3:0]  byte_enable;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mips_alu_control_unit dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
      .instr(instr), .reg_a(reg_a), .reg_b(reg_b),
      .alu_result(alu_result), .byte_offset(byte_offset),
      .branch_taken(branch_taken), .is_branch(is_branch), .pc_sel(pc_sel),
      .reg_write_enable(reg_write_enable), .reg_addr_sel(reg_addr_sel),
      .reg_data_sel(reg_data_sel), .signextend_sel(signextend_sel),
      .lwlr_sel(lwlr_sel), .data_read(data_read), .data_write(data_write),
      .byte_enable(byte_enable), .hi(hi), .lo(lo)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      instr = i; reg_a = a; reg_b = b;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // rs=1 rt=2 rd=3
   function automatic logic [31:0] rt_op(input logic [5:0] fn, input logic [4:0] sh);
      return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
   endfunction

   function automatic logic [31:0] it_op(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
      return {op, 5'd1, rt, imm};
   endfunction

   initial begin
      reset = 1'b1; clk_enable = 1'b1; active = 1'b1;
      instr = 32'h0; reg_a = 32'h0; reg_b = 32'h0;
      tick;
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      @(negedge clk); reset = 1'b0;

      // ALU R-type
      drive(rt_op(6'h21, 5'd0), 32'hFFFF_FFFF, 32'h2);                  // ADDU
      chk("addu_res", alu_result, 32'h1);
      chk("addu_we", reg_write_enable, 1'b1);
      chk("addu_addr", reg_addr_sel, 2'd1);
      chk("addu_isbr", is_branch, 1'b0);
      drive(rt_op(6'h23, 5'd0), 32'h5, 32'h7);                          // SUBU
      chk("subu_res", alu_result, 32'hFFFF_FFFE);
      drive(rt_op(6'h27, 5'd0), 32'hF0F0_0000, 32'h0000_00FF);          // NOR
      chk("nor_res", alu_result, 32'h0F0F_FF00);
      drive(rt_op(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'h1);                  // SLT
      chk("slt_res", alu_result, 32'h1);
      drive(rt_op(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'h1);                  // SLTU
      chk("sltu_res", alu_result, 32'h0);
      drive(rt_op(6'h03, 5'd4), 32'h0, 32'h8000_0000);                  // SRA 4
      chk("sra_res", alu_result, 32'hF800_0000);
      drive(rt_op(6'h02, 5'd4), 32'h0, 32'h8000_0000);                  // SRL 4
      chk("srl_res", alu_result, 32'h0800_0000);
      drive(rt_op(6'h04, 5'd0), 32'h24, 32'h1);                         // SLLV by a[4:0]=4
      chk("sllv_res", alu_result, 32'h10);

      // ALU immediates
      drive(it_op(6'h0A, 5'd2, 16'hFFFF), 32'hFFFF_FFFE, 32'h0);        // SLTI
      chk("slti_res", alu_result, 32'h1);
      chk("slti_addr", reg_addr_sel, 2'd0);
      drive(it_op(6'h0B, 5'd2, 16'hFFFF), 32'hFFFF_FFFE, 32'h0);        // SLTIU
      chk("sltiu_res", alu_result, 32'h1);
      drive(it_op(6'h0D, 5'd2, 16'h8000), 32'h0, 32'h0);                // ORI
      chk("ori_res", alu_result, 32'h0000_8000);
      drive(it_op(6'h0C, 5'd2, 16'h8000), 32'hFFFF_FFFF, 32'h0);        // ANDI
      chk("andi_res", alu_result, 32'h0000_8000);
      drive(it_op(6'h09, 5'd2, 16'hFFFF), 32'h10, 32'h0);               // ADDIU
      chk("addiu_res", alu_result, 32'hF);
      drive(it_op(6'h0F, 5'd2, 16'h1234), 32'hFFFF_FFFF, 32'h0);        // LUI
      chk("lui_res", alu_result, 32'h1234_0000);

      // Branches and jumps
      drive(it_op(6'h01, 5'h11, 16'h0004), 32'h8000_0000, 32'h0);       // BGEZAL not taken
      chk("bgezal_taken", branch_taken, 1'b0);
      chk("bgezal_pcsel", pc_sel, 2'd0);
      chk("bgezal_isbr", is_branch, 1'b1);
      chk("bgezal_we", reg_write_enable, 1'b1);
      chk("bgezal_addr", reg_addr_sel, 2'd2);
      chk("bgezal_data", reg_data_sel, 2'd3);
      drive(it_op(6'h01, 5'h00, 16'h0004), 32'h8000_0000, 32'h0);       // BLTZ taken
      chk("bltz_pcsel", pc_sel, 2'd1);
      chk("bltz_we", reg_write_enable, 1'b0);
      drive(it_op(6'h04, 5'd2, 16'h0004), 32'h55, 32'h55);              // BEQ taken
      chk("beq_taken", branch_taken, 1'b1);
      chk("beq_pcsel", pc_sel, 2'd1);
      drive(it_op(6'h05, 5'd2, 16'h0004), 32'h55, 32'h55);              // BNE not taken
      chk("bne_pcsel", pc_sel, 2'd0);
      chk("bne_isbr", is_branch, 1'b1);
      drive(it_op(6'h06, 5'd0, 16'h0004), 32'h0, 32'h0);                // BLEZ a=0
      chk("blez_taken", branch_taken, 1'b1);
      drive(it_op(6'h07, 5'd0, 16'h0004), 32'h0, 32'h0);                // BGTZ a=0
      chk("bgtz_taken", branch_taken, 1'b0);
      drive({6'h02, 26'h0000_100}, 32'h0, 32'h0);                       // J
      chk("j_pcsel", pc_sel, 2'd2);
      chk("j_we", reg_write_enable, 1'b0);
      drive({6'h03, 26'h0000_100}, 32'h0, 32'h0);                       // JAL
      chk("jal_addr", reg_addr_sel, 2'd2);
      chk("jal_data", reg_data_sel, 2'd3);
      drive(rt_op(6'h09, 5'd0), 32'h400, 32'h0);                        // JALR
      chk("jalr_pcsel", pc_sel, 2'd3);
      chk("jalr_addr", reg_addr_sel, 2'd1);
      chk("jalr_we", reg_write_enable, 1'b1);

      // Loads and stores
      drive(it_op(6'h29, 5'd2, 16'h0000), 32'h1002, 32'h0);             // SH upper half
      chk("sh_be", byte_enable, 4'b1100);
      chk("sh_dw", data_write, 1'b1);
      chk("sh_off", byte_offset, 2'd2);
      active = 1'b0; #1;
      chk("sh_idle_dw", data_write, 1'b0);
      chk("sh_idle_be", byte_enable, 4'b0000);
      active = 1'b1;
      drive(it_op(6'h28, 5'd2, 16'h0000), 32'h3, 32'h0);                // SB lane 3
      chk("sb_be", byte_enable, 4'b1000);
      drive(it_op(6'h20, 5'd2, 16'hFFFF), 32'h10, 32'h0);               // LB
      chk("lb_addr", alu_result, 32'hF);
      chk("lb_rd", data_read, 1'b1);
      chk("lb_data", reg_data_sel, 2'd2);
      chk("lb_sext", signextend_sel, 1'b1);
      chk("lb_be", byte_enable, 4'b1111);
      drive(it_op(6'h25, 5'd2, 16'h0000), 32'h10, 32'h0);               // LHU
      chk("lhu_sext", signextend_sel, 1'b0);
      drive(it_op(6'h22, 5'd2, 16'h0001), 32'h10, 32'h0);               // LWL
      chk("lwl_sel", lwlr_sel, 2'b11);
      chk("lwl_data", reg_data_sel, 2'd1);
      drive(it_op(6'h26, 5'd2, 16'h0001), 32'h10, 32'h0);               // LWR
      chk("lwr_sel", lwlr_sel, 2'b10);

      // Undefined opcode behaves as NOP
      drive(it_op(6'h3F, 5'd2, 16'h0000), 32'h10, 32'h0);
      chk("nop_we", reg_write_enable, 1'b0);
      chk("nop_dr", data_read, 1'b0);
      chk("nop_pcsel", pc_sel, 2'd0);

      // HI/LO path
      drive(rt_op(6'h18, 5'd0), 32'hFFFF_FFFF, 32'h2); tick;            // MULT
      chk("mult_hi", hi, MD ? 32'hFFFF_FFFF : 32'h0);
      chk("mult_lo", lo, MD ? 32'hFFFF_FFFE : 32'h0);
      drive(rt_op(6'h10, 5'd0), 32'h0, 32'h0);                          // MFHI
      chk("mfhi_res", alu_result, MD ? 32'hFFFF_FFFF : 32'h0);
      chk("mfhi_data", reg_data_sel, 2'd0);
      chk("mfhi_addr", reg_addr_sel, 2'd1);
      chk("mfhi_we", reg_write_enable, 1'b1);
      drive(rt_op(6'h19, 5'd0), 32'hFFFF_FFFF, 32'h2); tick;            // MULTU
      chk("multu_hi", hi, MD ? 32'h1 : 32'h0);
      drive(rt_op(6'h1A, 5'd0), 32'hFFFF_FFF9, 32'h2); tick;            // DIV -7/2
      chk("div_lo", lo, MD ? 32'hFFFF_FFFD : 32'h0);
      chk("div_hi", hi, MD ? 32'hFFFF_FFFF : 32'h0);
      drive(rt_op(6'h1A, 5'd0), 32'h64, 32'h0); tick;                   // DIV by 0
      chk("div0_lo", lo, MD ? 32'hFFFF_FFFD : 32'h0);
      chk("div0_hi", hi, MD ? 32'hFFFF_FFFF : 32'h0);
      drive(rt_op(6'h1B, 5'd0), 32'h7, 32'h2); tick;                    // DIVU
      chk("divu_lo", lo, MD ? 32'h3 : 32'h0);
      chk("divu_hi", hi, MD ? 32'h1 : 32'h0);
      drive(rt_op(6'h11, 5'd0), 32'h55, 32'h0);                         // MTHI, gated
      clk_enable = 1'b0; tick;
      chk("gated_hi", hi, MD ? 32'h1 : 32'h0);
      drive(rt_op(6'h21, 5'd0), 32'h1, 32'h1);
      chk("gated_we", reg_write_enable, 1'b0);
      clk_enable = 1'b1;
      drive(rt_op(6'h13, 5'd0), 32'h1234, 32'h0); tick;                 // MTLO
      chk("mtlo_lo", lo, MD ? 32'h1234 : 32'h0);
      drive(rt_op(6'h12, 5'd0), 32'h0, 32'h0);                          // MFLO
      chk("mflo_res", alu_result, MD ? 32'h1234 : 32'h0);
      drive(rt_op(6'h13, 5'd0), 32'h5678, 32'h0);                       // reset beats MTLO
      reset = 1'b1; tick;
      chk("rst_lo", lo, 32'h0);
      chk("rst_hi2", hi, 32'h0);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_alu_control_unit.md
MIPS_ALU_CONTROL_UNIT -- requirements
Module: mips_alu_control_unit

Interface
REQ-001 SHALL use reset `reset`: synchronous, active-high; clock `clk`.
REQ-002 SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  sync reset.
- clk_enable  in  1  cycle qualifier.
- active  in  1  CPU running.
- instr  in  32  current instruction.
- reg_a / reg_b  in  32  rs / rt contents.
- alu_result  out  32  result or effective address.
- byte_offset  out  2  alu_result[1:0].
- branch_taken  out  1  branch condition true.
- is_branch  out  1  any branch/jump.
- pc_sel  out  2  0 pc+4, 1 branch target, 2 jump imm, 3 jump reg.
- reg_write_enable  out  1  GPR write.
- reg_addr_sel  out  2  0 rt, 1 rd, 2 r31.
- reg_data_sel  out  2  0 alu_result, 1 raw mem word, 2 extended mem data, 3 link pc.
- signextend_sel  out  1  1 sign-extend, 0 zero-extend.
- lwlr_sel  out  2  bit1 LWL/LWR, bit0 LWL.
- data_read / data_write  out  1  memory strobes.
- byte_enable  out  4  store lanes.
- hi / lo  out  32  HI/LO registers.

Function
REQ-003 SHALL decode ADDU SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV JR JALR MULT MULTU DIV DIVU MFHI MFLO MTHI MTLO ADDIU ANDI ORI XORI SLTI SLTIU LUI BEQ BNE BLEZ BGTZ BLTZ BGEZ BLTZAL BGEZAL J JAL LB LBU LH LHU LW LWL LWR SB SH SW; all other encodings SHALL behave as NOP (all enables 0, pc_sel 0).
REQ-004 ALU B operand SHALL be reg_b for R-type/branches, else the immediate: zero-extended for ANDI/ORI/XORI, sign-extended otherwise; LUI result = imm<<16.
REQ-005 Arithmetic SHALL wrap mod 2^32 with no overflow trap; SLT/SLTI signed compare, SLTU/SLTIU unsigned, result 0/1.
REQ-006 Shifts: SLL/SRL/SRA use shamt instr[10:6]; variable forms use reg_a[4:0] and shift reg_b.
REQ-007 Loads/stores: alu_result = reg_a + sext(imm); data_read=1 for loads; data_write=1 for stores.
REQ-008 byte_enable: SB 4'b0001<<byte_offset; SH 4'b0011 (offset[1]=0) or 4'b1100; SW/loads 4'b1111; otherwise 0.
REQ-009 reg_data_sel: LW 1; LB/LBU/LH/LHU 2 with signextend_sel 1 for LB/LH, 0 for LBU/LHU; LWL/LWR 1 with lwlr_sel 2'b11/2'b10; JAL/JALR/BLTZAL/BGEZAL 3; all else 0.
REQ-010 Branch conditions: BEQ a==b, BNE a!=b, BLEZ a<=0, BGTZ a>0, BLTZ(AL) a<0, BGEZ(AL) a>=0, signed; pc_sel=1 only when taken.
REQ-011 is_branch SHALL be 1 for every branch and jump regardless of outcome.
REQ-012 BLTZAL/BGEZAL SHALL write r31 (reg_addr_sel 2) whether or not taken; JAL writes r31; JALR writes rd.
REQ-013 MULT/MULTU SHALL load {hi,lo} with the signed/unsigned 64-bit product at the next enabled edge.
REQ-014 DIV/DIVU SHALL load lo=quotient, hi=remainder (signed: truncate toward zero); divisor 0 SHALL leave HI/LO unchanged.
REQ-015 MTHI/MTLO SHALL load reg_a; MFHI/MFLO SHALL drive alu_result = hi/lo with reg_data_sel 0, reg_addr_sel 1.
REQ-016 Outputs other than hi/lo SHALL be combinational from instr, reg_a, reg_b (zero latency).
REQ-017 When active=0 or clk_enable=0: reg_write_enable, data_read, data_write SHALL be 0, byte_enable 0, and HI/LO SHALL hold.

Reset
REQ-018 At a reset edge hi and lo SHALL become 0; reset SHALL override clk_enable and any in-flight MULT/DIV.

Configuration
REQ-019 Macro MIPS_MULDIV_EN: when defined, REQ-013..REQ-015 apply; when undefined, MULT/MULTU/DIV/DIVU/MTHI/MTLO SHALL be NOPs, HI/LO SHALL stay 0, and MFHI/MFLO SHALL write 0.

Structure
REQ-020 Package mips_alu_pkg SHALL hold opcode/funct/regimm constants, the ALU operation enum, and the pc_sel/reg_addr_sel/reg_data_sel encodings.
REQ-021 Combinational datapath SHALL be sub-module mips_alu_core; decode and HI/LO registers live in the top.

Verification
REQ-022 ADDU, reg_a=0xFFFFFFFF, reg_b=2 -> alu_result 0x00000001, reg_write_enable 1, reg_addr_sel 1.
REQ-023 SLTI imm=0xFFFF, reg_a=0xFFFFFFFE -> alu_result 1; SLTIU same operands -> 1; ORI imm=0x8000, reg_a=0 -> 0x00008000.
REQ-024 BGEZAL, reg_a=0x80000000 -> branch_taken 0, pc_sel 0, is_branch 1, reg_write_enable 1, reg_addr_sel 2, reg_data_sel 3.
REQ-025 MULT 0xFFFFFFFF*2 then MFHI -> hi 0xFFFFFFFF, lo 0xFFFFFFFE; DIV -7/2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF; DIV by 0 -> HI/LO unchanged.
REQ-026 SH with reg_a=0x1002, imm=0 -> byte_enable 4'b1100, data_write 1; same with active=0 -> data_write 0, byte_enable 0.
REQ-027 MTLO 0x1234 then reset -> lo 0 on the next edge.
